lc3_control_fsm: RTL and testbench
==================================

LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high; clock Clk.
REQ-003 Run  input  1  start request from HALTED; level-sampled.
REQ-004 Continue  input  1  resume request from pause states; level-sampled.
REQ-005 Opcode  input  4  IR[15:12].
REQ-006 IR_5  input  1  IR[5]: immediate select for ADD/AND.
REQ-007 IR_11  input  1  IR[11]: JSR vs JSRR select.
REQ-008 BEN  input  1  registered branch-enable from datapath.
REQ-009 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load strobes.
REQ-010 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle.
REQ-011 PCMUX  output  2  00=PC+1, 01=bus, 10=adder.
REQ-012 DRMUX, SR1MUX, SR2MUX, ADDR1MUX  output  1 each  datapath selects.
REQ-013 ADDR2MUX  output  2  00=0, 01=offset6, 10=offset9, 11=offset11.
REQ-014 ALUK  output  2  00=ADD, 01=AND, 10=NOT, 11=PASS.
REQ-015 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  SRAM controls, active-low.

Function
REQ-016 Moore FSM: all outputs SHALL be decoded from the current state only; default every strobe/gate 0, selects 0, Mem_OE/Mem_WE 1, Mem_CE/UB/LB 0.
REQ-017 HALTED: stay while Run=0; Run=1 -> S18.
REQ-018 S18: GatePC, LD_MAR, PCMUX=00, LD_PC -> S33_1.
REQ-019 S33_1, S33_2: Mem_OE=0; S33_3: Mem_OE=0, LD_MDR -> S35. Fixed 3-cycle read latency.
REQ-020 S35: GateMDR, LD_IR -> S32.
REQ-021 S32: LD_BEN; decode Opcode: 0001->S01, 0101->S05, 1001->S09, 0000->S00, 1100->S12, 0100->S04, 0110->S06, 0111->S07, 1101->PAUSE_1; any other opcode -> S18 (NOP).
REQ-022 S01/S05: SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC -> S18. S09: ALUK=10, GateALU, LD_REG, LD_CC -> S18.
REQ-023 S00: BEN=1 -> S22, else -> S18. S22: ADDR1MUX=PC, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
REQ-024 S12: ADDR1MUX=BaseR, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
REQ-025 S04: DRMUX=1 (R7), GatePC, LD_REG -> S21. S21: IR_11=1 ADDR1MUX=PC, ADDR2MUX=11; IR_11=0 ADDR1MUX=BaseR, ADDR2MUX=00; PCMUX=10, LD_PC -> S18.
REQ-026 S06: ADDR1MUX=BaseR, ADDR2MUX=01, GateMARMUX, LD_MAR -> S25_1; S25_1..S25_3 as REQ-019 -> S27; S27: GateMDR, LD_REG, LD_CC -> S18.
REQ-027 S07: address as S06 -> S23; S23: SR1MUX=1 (IR[11:9]), ALUK=11, GateALU, LD_MDR -> S16_1; S16_1..S16_3: Mem_WE=0 -> S18.
REQ-028 PAUSE_1: LD_LED; hold while Continue=0; Continue=1 -> PAUSE_2. PAUSE_2: hold while Continue=1; Continue=0 -> S18 (one instruction per Continue press).
REQ-029 Run does not affect non-HALTED states.

Reset
REQ-030 Reset=1 at any edge SHALL force HALTED regardless of state, including mid-memory-cycle; outputs take HALTED defaults next cycle.
REQ-031 Reset has priority over Run and Continue.

Structure
REQ-032 State enum, ALUK/PCMUX/ADDR2MUX encodings, and opcode constants SHALL live in shared package lc3_pkg.
REQ-033 Single module, two processes (state register, next-state/output decode); no sub-module.

Verification
REQ-034 Reset high 2 cycles, Run=0 -> HALTED, all strobes 0, Mem_OE=1, Mem_WE=1.
REQ-035 Run=1, Opcode=0001, IR_5=1 -> S18,S33_1..3,S35,S32,S01,S18; S01 shows SR2MUX=1, GateALU, LD_REG, LD_CC.
REQ-036 Opcode=0000, BEN=0 -> S00 then S18, LD_PC never asserted in S00; BEN=1 -> S22 with PCMUX=10.
REQ-037 Opcode=0111 -> Mem_WE=0 for exactly 3 cycles, Mem_OE=1 throughout.
REQ-038 Opcode=1101, Continue held 0 for 10 cycles -> remains PAUSE_1; pulse 1 then 0 -> S18 next fetch.
REQ-039 Reset asserted during S33_2 -> HALTED next cycle, LD_MDR never asserted.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and encodings for the LC-3 control FSM.
// Holds the state enumeration, datapath select encodings (PCMUX, ADDR1MUX,
// ADDR2MUX, ALUK) and the opcode constants decoded in S32.
package lc3_pkg;

   typedef enum logic [4:0] {
      HALTED,
      S18,
      S33_1,
      S33_2,
      S33_3,
      S35,
      S32,
      S01,
      S05,
      S09,
      S00,
      S22,
      S12,
      S04,
      S21,
      S06,
      S25_1,
      S25_2,
      S25_3,
      S27,
      S07,
      S23,
      S16_1,
      S16_2,
      S16_3,
      PAUSE_1,
      PAUSE_2
   } state_t;

   localparam logic [1:0] PCMUX_INC   = 2'b00;
   localparam logic [1:0] PCMUX_BUS   = 2'b01;
   localparam logic [1:0] PCMUX_ADDER = 2'b10;

   localparam logic       ADDR1_PC    = 1'b0;
   localparam logic       ADDR1_BASER = 1'b1;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   localparam logic [1:0] ALUK_ADD    = 2'b00;
   localparam logic [1:0] ALUK_AND    = 2'b01;
   localparam logic [1:0] ALUK_NOT    = 2'b10;
   localparam logic [1:0] ALUK_PASS   = 2'b11;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

endpackage

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore control FSM for a simple LC-3 datapath.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   Run, Continue         start request (HALTED) / resume request (pause)
//   Opcode, IR_5, IR_11   instruction fields used for decode and selects
//   BEN                   registered branch enable from the datapath
//   LD_*                  register load strobes
//   Gate*                 bus drivers, at most one active per state
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK  datapath selects
//   Mem_CE/UB/LB/OE/WE    SRAM controls, active-low
//
// state   | meaning
// --------+------------------------------------------------------------
// HALTED  | idle until Run
// S18     | MAR <- PC, PC <- PC+1
// S33_1..3| instruction read, fixed 3-cycle latency, MDR loaded in S33_3
// S35     | IR <- MDR
// S32     | BEN load, opcode decode
// S01/S05 | ADD / AND (SR2MUX follows IR[5])
// S09     | NOT
// S00     | branch test on BEN
// S22     | PC <- PC + offset9
// S12     | JMP: PC <- BaseR
// S04     | JSR/JSRR: R7 <- PC
// S21     | JSR (PC + offset11) or JSRR (BaseR)
// S06     | LDR address: MAR <- BaseR + offset6
// S25_1..3| data read, MDR loaded in S25_3
// S27     | DR <- MDR, set CC
// S07     | STR address: MAR <- BaseR + offset6
// S23     | MDR <- SR
// S16_1..3| data write, WE low 3 cycles
// PAUSE_1 | show LED, wait for Continue press
// PAUSE_2 | wait for Continue release
module lc3_control_fsm
   import lc3_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_CE,
   output logic       Mem_UB,
   output logic       Mem_LB,
   output logic       Mem_OE,
   output logic       Mem_WE
);

   state_t state, state_nxt;

   always_ff @(posedge Clk) begin
      if (Reset)
         state <= HALTED;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      PCMUX      = PCMUX_INC;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = ADDR1_PC;
      ADDR2MUX   = ADDR2_ZERO;
      ALUK       = ALUK_ADD;
      // Chip and byte enables stay asserted; OE/WE alone select the access.
      Mem_CE     = 1'b0;
      Mem_UB     = 1'b0;
      Mem_LB     = 1'b0;
      Mem_OE     = 1'b1;
      Mem_WE     = 1'b1;

      case (state)
         HALTED: if (Run) state_nxt = S18;
         S18: begin
            GatePC    = 1'b1;
            LD_MAR    = 1'b1;
            PCMUX     = PCMUX_INC;
            LD_PC     = 1'b1;
            state_nxt = S33_1;
         end
         S33_1: begin
            Mem_OE    = 1'b0;
            state_nxt = S33_2;
         end
         S33_2: begin
            Mem_OE    = 1'b0;
            state_nxt = S33_3;
         end
         S33_3: begin
            Mem_OE    = 1'b0;
            LD_MDR    = 1'b1;
            state_nxt = S35;
         end
         S35: begin
            GateMDR   = 1'b1;
            LD_IR     = 1'b1;
            state_nxt = S32;
         end
         S32: begin
            LD_BEN = 1'b1;
            case (Opcode)
               OP_ADD:   state_nxt = S01;
               OP_AND:   state_nxt = S05;
               OP_NOT:   state_nxt = S09;
               OP_BR:    state_nxt = S00;
               OP_JMP:   state_nxt = S12;
               OP_JSR:   state_nxt = S04;
               OP_LDR:   state_nxt = S06;
               OP_STR:   state_nxt = S07;
               OP_PAUSE: state_nxt = PAUSE_1;
               default:  state_nxt = S18;
            endcase
         end
         S01, S05, S09: begin
            // NOT has no second operand, so SR2MUX stays at its default there.
            if (state != S09) SR2MUX = IR_5;
            ALUK      = (state == S01) ? ALUK_ADD :
                        (state == S05) ? ALUK_AND : ALUK_NOT;
            GateALU   = 1'b1;
            LD_REG    = 1'b1;
            LD_CC     = 1'b1;
            state_nxt = S18;
         end
         S00: state_nxt = BEN ? S22 : S18;
         S22: begin
            ADDR1MUX  = ADDR1_PC;
            ADDR2MUX  = ADDR2_OFF9;
            PCMUX     = PCMUX_ADDER;
            LD_PC     = 1'b1;
            state_nxt = S18;
         end
         S12: begin
            ADDR1MUX  = ADDR1_BASER;
            ADDR2MUX  = ADDR2_ZERO;
            PCMUX     = PCMUX_ADDER;
            LD_PC     = 1'b1;
            state_nxt = S18;
         end
         S04: begin
            DRMUX     = 1'b1;
            GatePC    = 1'b1;
            LD_REG    = 1'b1;
            state_nxt = S21;
         end
         S21: begin
            ADDR1MUX  = IR_11 ? ADDR1_PC : ADDR1_BASER;
            ADDR2MUX  = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
            PCMUX     = PCMUX_ADDER;
            LD_PC     = 1'b1;
            state_nxt = S18;
         end
         S06, S07: begin
            ADDR1MUX   = ADDR1_BASER;
            ADDR2MUX   = ADDR2_OFF6;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
            state_nxt  = (state == S06) ? S25_1 : S23;
         end
         S25_1: begin
            Mem_OE    = 1'b0;
            state_nxt = S25_2;
         end
         S25_2: begin
            Mem_OE    = 1'b0;
            state_nxt = S25_3;
         end
         S25_3: begin
            Mem_OE    = 1'b0;
            LD_MDR    = 1'b1;
            state_nxt = S27;
         end
         S27: begin
            GateMDR   = 1'b1;
            LD_REG    = 1'b1;
            LD_CC     = 1'b1;
            state_nxt = S18;
         end
         S23: begin
            SR1MUX    = 1'b1;
            ALUK      = ALUK_PASS;
            GateALU   = 1'b1;
            LD_MDR    = 1'b1;
            state_nxt = S16_1;
         end
         S16_1: begin
            Mem_WE    = 1'b0;
            state_nxt = S16_2;
         end
         S16_2: begin
            Mem_WE    = 1'b0;
            state_nxt = S16_3;
         end
         S16_3: begin
            Mem_WE    = 1'b0;
            state_nxt = S18;
         end
         PAUSE_1: begin
            LD_LED = 1'b1;
            if (Continue) state_nxt = PAUSE_2;
         end
         // Waiting for release makes one press advance exactly one instruction.
         PAUSE_2: if (!Continue) state_nxt = S18;
         default: state_nxt = HALTED;
      endcase
   end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed self-checking bench for lc3_control_fsm.
// Each cycle the full output set is packed into one word and compared
// against hand-built per-state expected words.
module tb_lc3_control_fsm;

   logic       Clk = 1'b0;
   logic       Reset, Run, Continue, IR_5, IR_11, BEN;
   logic [3:0] Opcode;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
   logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

   int tests  = 0;
   int failed = 0;

   lc3_control_fsm dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );

   always #5 Clk = ~Clk;

   // Packed layout:
   // [26]LD_MAR [25]LD_MDR [24]LD_IR [23]LD_BEN [22]LD_CC [21]LD_REG [20]LD_PC [19]LD_LED
   // [18]GatePC [17]GateMDR [16]GateALU [15]GateMARMUX [14:13]PCMUX [12]DRMUX [11]SR1MUX
   // [10]SR2MUX [9]ADDR1MUX [8:7]ADDR2MUX [6:5]ALUK [4]CE [3]UB [2]LB [1]OE [0]WE
   localparam logic [26:0] M_LD_MAR  = 27'h1 << 26;
   localparam logic [26:0] M_LD_MDR  = 27'h1 << 25;
   localparam logic [26:0] M_LD_IR   = 27'h1 << 24;
   localparam logic [26:0] M_LD_BEN  = 27'h1 << 23;
   localparam logic [26:0] M_LD_CC   = 27'h1 << 22;
   localparam logic [26:0] M_LD_REG  = 27'h1 << 21;
   localparam logic [26:0] M_LD_PC   = 27'h1 << 20;
   localparam logic [26:0] M_LD_LED  = 27'h1 << 19;
   localparam logic [26:0] M_G_PC    = 27'h1 << 18;
   localparam logic [26:0] M_G_MDR   = 27'h1 << 17;
   localparam logic [26:0] M_G_ALU   = 27'h1 << 16;
   localparam logic [26:0] M_G_MARM  = 27'h1 << 15;
   localparam logic [26:0] M_PC_ADD  = 27'h1 << 14;   // PCMUX = 10
   localparam logic [26:0] M_DRMUX   = 27'h1 << 12;
   localparam logic [26:0] M_SR1MUX  = 27'h1 << 11;
   localparam logic [26:0] M_SR2MUX  = 27'h1 << 10;
   localparam logic [26:0] M_A1_BASE = 27'h1 << 9;
   localparam logic [26:0] M_A2_OFF6 = 27'h1 << 7;    // ADDR2MUX = 01
   localparam logic [26:0] M_A2_OFF9 = 27'h1 << 8;    // ADDR2MUX = 10
   localparam logic [26:0] M_A2_O11  = 27'h3 << 7;    // ADDR2MUX = 11
   localparam logic [26:0] M_K_AND   = 27'h1 << 5;
   localparam logic [26:0] M_K_NOT   = 27'h1 << 6;
   localparam logic [26:0] M_K_PASS  = 27'h3 << 5;
   localparam logic [26:0] M_OE      = 27'h1 << 1;
   localparam logic [26:0] M_WE      = 27'h1;

   localparam logic [26:0] E_DEF   = M_OE | M_WE;
   localparam logic [26:0] E_S18   = E_DEF | M_G_PC | M_LD_MAR | M_LD_PC;
   localparam logic [26:0] E_RD    = M_WE;
   localparam logic [26:0] E_RD_LD = M_WE | M_LD_MDR;
   localparam logic [26:0] E_S35   = E_DEF | M_G_MDR | M_LD_IR;
   localparam logic [26:0] E_S32   = E_DEF | M_LD_BEN;
   localparam logic [26:0] E_ALU   = E_DEF | M_G_ALU | M_LD_REG | M_LD_CC;
   localparam logic [26:0] E_S22   = E_DEF | M_A2_OFF9 | M_PC_ADD | M_LD_PC;
   localparam logic [26:0] E_S12   = E_DEF | M_A1_BASE | M_PC_ADD | M_LD_PC;
   localparam logic [26:0] E_S04   = E_DEF | M_DRMUX | M_G_PC | M_LD_REG;
   localparam logic [26:0] E_S21J  = E_DEF | M_A2_O11 | M_PC_ADD | M_LD_PC;
   localparam logic [26:0] E_ADDR  = E_DEF | M_A1_BASE | M_A2_OFF6 | M_G_MARM | M_LD_MAR;
   localparam logic [26:0] E_S27   = E_DEF | M_G_MDR | M_LD_REG | M_LD_CC;
   localparam logic [26:0] E_S23   = E_DEF | M_SR1MUX | M_K_PASS | M_G_ALU | M_LD_MDR;
   localparam logic [26:0] E_WR    = M_OE;
   localparam logic [26:0] E_P1    = E_DEF | M_LD_LED;

   function automatic logic [26:0] obs();
      return {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
              GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
              SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
              Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
   endfunction

   task automatic do_reset();
      Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [26:0] o;
      Reset = 1'b1; Run = 1'b1; Continue = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      o = obs(); tests++;
      if (o !== E_DEF) begin failed++; $display("FAIL reset_priority got %h exp %h", o, E_DEF); end
      Run = 1'b0; Continue = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== E_DEF) begin failed++; $display("FAIL halted_hold cyc%0d got %h exp %h", i, o, E_DEF); end
      end
   endtask

   task automatic test_alu(input logic [3:0] op, input logic ir5, input logic [26:0] e_exec);
      logic [26:0] exp [8];
      logic [26:0] o;
      exp = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, e_exec, E_S18};
      do_reset();
      Opcode = op; IR_5 = ir5; Run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exp[i]) begin failed++; $display("FAIL alu op%b cyc%0d got %h exp %h", op, i, o, exp[i]); end
      end
      Run = 1'b0;
   endtask

   task automatic test_branch();
      logic [26:0] exp0 [8];
      logic [26:0] exp1 [9];
      logic [26:0] o;
      exp0 = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_DEF, E_S18};
      exp1 = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_DEF, E_S22, E_S18};
      do_reset();
      Opcode = 4'b0000; BEN = 1'b0; Run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exp0[i]) begin failed++; $display("FAIL br_not_taken cyc%0d got %h exp %h", i, o, exp0[i]); end
      end
      do_reset();
      BEN = 1'b1; Run = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exp1[i]) begin failed++; $display("FAIL br_taken cyc%0d got %h exp %h", i, o, exp1[i]); end
      end
      BEN = 1'b0; Run = 1'b0;
   endtask

   task automatic test_jumps();
      logic [26:0] expj [8];
      logic [26:0] exps [9];
      logic [26:0] expr [9];
      logic [26:0] o;
      expj = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_S12, E_S18};
      exps = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_S04, E_S21J, E_S18};
      expr = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_S04, E_S12, E_S18};
      do_reset();
      Opcode = 4'b1100; Run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== expj[i]) begin failed++; $display("FAIL jmp cyc%0d got %h exp %h", i, o, expj[i]); end
      end
      do_reset();
      Opcode = 4'b0100; IR_11 = 1'b1; Run = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exps[i]) begin failed++; $display("FAIL jsr cyc%0d got %h exp %h", i, o, exps[i]); end
      end
      // JSRR drives the same selects as JMP in S21.
      do_reset();
      IR_11 = 1'b0; Run = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== expr[i]) begin failed++; $display("FAIL jsrr cyc%0d got %h exp %h", i, o, expr[i]); end
      end
      Run = 1'b0;
   endtask

   task automatic test_memory();
      logic [26:0] expl [12];
      logic [26:0] exps [12];
      logic [26:0] o;
      expl = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_ADDR, E_RD, E_RD, E_RD_LD, E_S27, E_S18};
      exps = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_ADDR, E_S23, E_WR, E_WR, E_WR, E_S18};
      do_reset();
      Opcode = 4'b0110; Run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== expl[i]) begin failed++; $display("FAIL ldr cyc%0d got %h exp %h", i, o, expl[i]); end
      end
      do_reset();
      Opcode = 4'b0111; Run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exps[i]) begin failed++; $display("FAIL str cyc%0d got %h exp %h", i, o, exps[i]); end
      end
      Run = 1'b0;
   endtask

   task automatic test_nop();
      logic [26:0] exp [8];
      logic [26:0] o;
      exp = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32, E_S18, E_RD};
      do_reset();
      Opcode = 4'b1111; Run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exp[i]) begin failed++; $display("FAIL nop cyc%0d got %h exp %h", i, o, exp[i]); end
      end
      Run = 1'b0;
   endtask

   task automatic test_pause();
      logic [26:0] exp [6];
      logic [26:0] o;
      exp = '{E_S18, E_RD, E_RD, E_RD_LD, E_S35, E_S32};
      do_reset();
      Opcode = 4'b1101; Run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exp[i]) begin failed++; $display("FAIL pause_fetch cyc%0d got %h exp %h", i, o, exp[i]); end
      end
      Run = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== E_P1) begin failed++; $display("FAIL pause_hold cyc%0d got %h exp %h", i, o, E_P1); end
      end
      Continue = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== E_DEF) begin failed++; $display("FAIL pause_release cyc%0d got %h exp %h", i, o, E_DEF); end
      end
      Continue = 1'b0;
      @(posedge Clk); #1;
      o = obs(); tests++;
      if (o !== E_S18) begin failed++; $display("FAIL pause_resume got %h exp %h", o, E_S18); end
   endtask

   task automatic test_reset_mid_read();
      logic [26:0] exp [3];
      logic [26:0] o;
      exp = '{E_S18, E_RD, E_RD};
      do_reset();
      Opcode = 4'b0001; Run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== exp[i]) begin failed++; $display("FAIL midrst_fetch cyc%0d got %h exp %h", i, o, exp[i]); end
      end
      Reset = 1'b1;
      @(posedge Clk); #1;
      o = obs(); tests++;
      if (o !== E_DEF) begin failed++; $display("FAIL midrst_halted got %h exp %h", o, E_DEF); end
      Reset = 1'b0; Run = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge Clk); #1;
         o = obs(); tests++;
         if (o !== E_DEF) begin failed++; $display("FAIL midrst_stay cyc%0d got %h exp %h", i, o, E_DEF); end
      end
   endtask

   initial begin
      Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
      Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
      test_reset();
      test_alu(4'b0001, 1'b1, E_ALU | M_SR2MUX);
      test_alu(4'b0101, 1'b0, E_ALU | M_K_AND);
      test_alu(4'b1001, 1'b1, E_ALU | M_K_NOT);
      test_branch();
      test_jumps();
      test_memory();
      test_nop();
      test_pause();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
